// File: rtl/bitorder_pkg.sv
// Shared types and helpers for the bitorder_pp symbol reorder stage.
package bitorder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  localparam int RMII_SYM_W = 2;
  localparam int MII_SYM_W  = 4;

  // Buffer index to read on drain cycle cnt; mode=1 walks the group top-down.
  function automatic int unsigned drain_idx(input int unsigned cnt,
                                            input logic        mode,
                                            input int unsigned n);
    return mode ? (n - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/bitorder_pp_grp_buf.sv
// One group-sized symbol buffer with a full flag and the order mode captured
// alongside the group's first symbol.
module grp_buf #(
  parameter int SYM_W        = 2,
  parameter int SYMS_PER_GRP = 4,
  parameter int CNT_W        = $clog2(SYMS_PER_GRP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_idx_i,
  input  logic [SYM_W-1:0] wr_data_i,
  input  logic             wr_mode_i,
  input  logic             set_full_i,
  input  logic             clr_full_i,
  input  logic [CNT_W-1:0] rd_idx_i,
  output logic [SYM_W-1:0] rd_data_o,
  output logic             full_o,
  output logic             mode_o
);

  logic [SYM_W-1:0] mem_q [SYMS_PER_GRP];
  logic             full_q;
  logic             mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYMS_PER_GRP; i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_idx_i] <= wr_data_i;
        // The order mode belongs to the group, so it is latched only with index 0.
        if (wr_idx_i == '0) begin
          mode_q <= wr_mode_i;
        end
      end
      if (set_full_i) begin
        full_q <= 1'b1;
      end else if (clr_full_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign full_o    = full_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/bitorder_pp.sv
// Ping-pong symbol group reorder: collects SYMS_PER_GRP symbols, then replays
// them reversed (or in order) while the other buffer fills; partial groups drop.
module bitorder_pp
  import bitorder_pkg::*;
#(
  parameter int SYM_W        = RMII_SYM_W,
  parameter int SYMS_PER_GRP = 4,
  parameter int CNT_W        = $clog2(SYMS_PER_GRP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axiiv,
  input  logic [SYM_W-1:0] axiid,
  input  logic             msb_first,
  output logic             axiov,
  output logic [SYM_W-1:0] axiod,
  output logic             axiodrop,
  output logic             dbg_drain_o
);

  // Streams are valid-only: a symbol transfers on every cycle its valid is
  // high, there is no ready/backpressure, and input valid low ends the frame.

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS_PER_GRP - 1);

  // Fill side state
  logic             fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             drop_q, drop_d;

  // Drain side state
  drain_state_e     state_q, state_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  logic             handover;
  logic             drain_last;
  logic [1:0]       wr_en;
  logic [1:0]       set_full;
  logic [1:0]       clr_full;
  logic [1:0]       buf_full;
  logic [1:0]       buf_mode;
  logic [CNT_W-1:0] rd_idx;
  logic [SYM_W-1:0] rd_data [2];

  assign handover   = axiiv && (wcnt_q == LAST);
  assign drain_last = (state_q == DRAIN) && (rcnt_q == LAST);

  always_comb begin
    wr_en    = 2'b00;
    set_full = 2'b00;
    clr_full = 2'b00;
    if (axiiv) begin
      wr_en = fill_ptr_q ? 2'b10 : 2'b01;
    end
    if (handover) begin
      set_full = fill_ptr_q ? 2'b10 : 2'b01;
    end
    if (drain_last) begin
      clr_full = rd_ptr_q ? 2'b10 : 2'b01;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    grp_buf #(
      .SYM_W        (SYM_W),
      .SYMS_PER_GRP (SYMS_PER_GRP),
      .CNT_W        (CNT_W)
    ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en[b]),
      .wr_idx_i   (wcnt_q),
      .wr_data_i  (axiid),
      .wr_mode_i  (msb_first),
      .set_full_i (set_full[b]),
      .clr_full_i (clr_full[b]),
      .rd_idx_i   (rd_idx),
      .rd_data_o  (rd_data[b]),
      .full_o     (buf_full[b]),
      .mode_o     (buf_mode[b])
    );
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    fill_ptr_d = fill_ptr_q;
    drop_d     = 1'b0;
    if (axiiv) begin
      if (wcnt_q == LAST) begin
        wcnt_d     = '0;
        fill_ptr_d = ~fill_ptr_q;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end else if (wcnt_q != '0) begin
      // Frame ended mid-group: rewind so the partial data is overwritten.
      wcnt_d = '0;
      drop_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rcnt_d   = rcnt_q;
    case (state_q)
      IDLE: begin
        if (handover) begin
          state_d  = DRAIN;
          rd_ptr_d = fill_ptr_q;
          rcnt_d   = '0;
        end
      end
      DRAIN: begin
        if (rcnt_q != LAST) begin
          rcnt_d = rcnt_q + 1'b1;
        end else begin
          rcnt_d = '0;
          // Chain straight into the other buffer when it is (or just became) full.
          if (handover) begin
            rd_ptr_d = fill_ptr_q;
          end else if (buf_full[~rd_ptr_q]) begin
            rd_ptr_d = ~rd_ptr_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr_q <= 1'b0;
      wcnt_q     <= '0;
      drop_q     <= 1'b0;
      state_q    <= IDLE;
      rd_ptr_q   <= 1'b0;
      rcnt_q     <= '0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      wcnt_q     <= wcnt_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign rd_idx      = CNT_W'(drain_idx(32'(rcnt_q), buf_mode[rd_ptr_q], SYMS_PER_GRP));
  assign axiov       = (state_q == DRAIN);
  assign axiod       = axiov ? rd_data[rd_ptr_q] : '0;
  assign axiodrop    = drop_q;
  assign dbg_drain_o = (state_q == DRAIN);

endmodule

// File: tb/tb_bitorder_pp.sv
// Directed bench for bitorder_pp: default RMII build plus a 4-bit, 2-symbol build.
module tb_bitorder_pp;

  logic       clk;
  logic       rst_n;
  logic       axiiv;
  logic [1:0] axiid;
  logic       msb_first;
  logic       axiov;
  logic [1:0] axiod;
  logic       axiodrop;
  logic       dbg_drain;

  logic       axiiv4;
  logic [3:0] axiid4;
  logic       msb4;
  logic       axiov4;
  logic [3:0] axiod4;
  logic       axiodrop4;
  logic       dbg_drain4;

  int vectors;
  int miscompares;

  bitorder_pp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .msb_first   (msb_first),
    .axiov       (axiov),
    .axiod       (axiod),
    .axiodrop    (axiodrop),
    .dbg_drain_o (dbg_drain)
  );

  bitorder_pp #(.SYM_W(4), .SYMS_PER_GRP(2)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .axiiv       (axiiv4),
    .axiid       (axiid4),
    .msb_first   (msb4),
    .axiov       (axiov4),
    .axiod       (axiod4),
    .axiodrop    (axiodrop4),
    .dbg_drain_o (dbg_drain4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic v, input logic [1:0] d, input logic m);
    axiiv     = v;
    axiid     = d;
    msb_first = m;
  endtask

  task automatic drive4(input logic v, input logic [3:0] d, input logic m);
    axiiv4 = v;
    axiid4 = d;
    msb4   = m;
  endtask

  // Each loop step: wait for the falling edge, check the cycle's outputs,
  // then apply that cycle's input. si/eo use -1 for "no symbol".
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b1);
    drive4(1'b0, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    vectors++;
    if (axiov !== 1'b0 || axiod !== 2'b00 || axiodrop !== 1'b0 || dbg_drain !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut: got v=%b d=%b drop=%b dbg=%b, expected all 0", axiov, axiod, axiodrop, dbg_drain);
    end
    vectors++;
    if (axiov4 !== 1'b0 || axiod4 !== 4'h0 || axiodrop4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut4: got v=%b d=%h drop=%b, expected all 0", axiov4, axiod4, axiodrop4);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int si[] = '{1, 1, 1, 3};
    int eo[] = '{-1, -1, -1, -1, 3, 1, 1, 1, -1, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00) || axiodrop !== 1'b0) begin
        miscompares++;
        $display("FAIL single t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=0", t, axiov, axiod, axiodrop, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size()) drive(1'b1, 2'(si[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int si[] = '{1, 1, 1, 3, 0, 1, 2, 2, 3, 0, 3, 1};
    int eo[] = '{-1, -1, -1, -1, 3, 1, 1, 1, 2, 2, 1, 0, 1, 3, 0, 3, -1, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00) || axiodrop !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=0", t, axiov, axiod, axiodrop, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size()) drive(1'b1, 2'(si[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
  endtask

  task automatic test_partial();
    int si[] = '{1, 1, 1, 3, 0, 1};
    int eo[] = '{-1, -1, -1, -1, 3, 1, 1, 1, -1, -1, -1, -1};
    logic edrop;
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      edrop = (t == 7);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00) || axiodrop !== edrop) begin
        miscompares++;
        $display("FAIL partial t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=%b", t, axiov, axiod, axiodrop, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0, edrop);
      end
      if (t < si.size()) drive(1'b1, 2'(si[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
  endtask

  task automatic test_lsb_first();
    // msb_first flips high after the first symbol; the group keeps mode 0.
    int si[] = '{1, 2, 3, 0};
    int eo[] = '{-1, -1, -1, -1, 1, 2, 3, 0, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00) || axiodrop !== 1'b0) begin
        miscompares++;
        $display("FAIL lsb_first t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=0", t, axiov, axiod, axiodrop, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size()) drive(1'b1, 2'(si[t]), (t != 0));
      else drive(1'b0, 2'b00, 1'b0);
    end
  endtask

  task automatic test_mii_param();
    int si[] = '{10, 5};
    int eo[] = '{-1, -1, 5, 10, -1, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov4 !== (eo[t] >= 0) || axiod4 !== ((eo[t] >= 0) ? 4'(eo[t]) : 4'h0) || axiodrop4 !== 1'b0) begin
        miscompares++;
        $display("FAIL mii_param t=%0d: got v=%b d=%h drop=%b, expected v=%b d=%0d drop=0", t, axiov4, axiod4, axiodrop4, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size()) drive4(1'b1, 4'(si[t]), 1'b1);
      else drive4(1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_drain();
    int si[] = '{1, 1, 1, 3};
    int eo[] = '{-1, -1, -1, -1, 3, 1};
    int si2[] = '{0, 1, 2, 3};
    int eo2[] = '{-1, -1, -1, -1, 3, 2, 1, 0, -1, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00)) begin
        miscompares++;
        $display("FAIL rst_pre t=%0d: got v=%b d=%b, expected v=%b d=%0d", t, axiov, axiod, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size()) drive(1'b1, 2'(si[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (axiov !== 1'b0 || axiod !== 2'b00 || axiodrop !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got v=%b d=%b drop=%b, expected 0 0 0", axiov, axiod, axiodrop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < eo2.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo2[t] >= 0) || axiod !== ((eo2[t] >= 0) ? 2'(eo2[t]) : 2'b00) || axiodrop !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_post t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=0", t, axiov, axiod, axiodrop, eo2[t] >= 0, (eo2[t] >= 0) ? eo2[t] : 0);
      end
      if (t < si2.size()) drive(1'b1, 2'(si2[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
  endtask

  task automatic test_idle_gap();
    int si[] = '{2, 0, 1, 3, -1, -1, -1, 3, 2, 0, 1};
    int eo[] = '{-1, -1, -1, -1, 3, 1, 0, 2, -1, -1, -1, 1, 0, 2, 3, -1};
    for (int t = 0; t < eo.size(); t++) begin
      @(negedge clk);
      vectors++;
      if (axiov !== (eo[t] >= 0) || axiod !== ((eo[t] >= 0) ? 2'(eo[t]) : 2'b00) || axiodrop !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_gap t=%0d: got v=%b d=%b drop=%b, expected v=%b d=%0d drop=0", t, axiov, axiod, axiodrop, eo[t] >= 0, (eo[t] >= 0) ? eo[t] : 0);
      end
      if (t < si.size() && si[t] >= 0) drive(1'b1, 2'(si[t]), 1'b1);
      else drive(1'b0, 2'b00, 1'b1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial();
    test_lsb_first();
    test_mii_param();
    test_reset_mid_drain();
    test_idle_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitorder_pp.md
Name: bitorder_pp

Overview:
- Parametrised successor to the RMII dibit reorder stage.
- Collects fixed-size groups of SYM_W-bit symbols, which arrive LSB-symbol-first, and re-emits each complete group MSB-symbol-first (or in original order when reordering is off).
- Ping-pong buffered, so back-to-back groups stream with no bubbles; partial trailing groups are dropped and flagged.
- Sits between the PHY receive interface and the CRC/header parsers.

Parameters:
- SYM_W, 2, bits per symbol; 2 = RMII dibit, 4 = MII nibble.
- SYMS_PER_GRP, 4, symbols per group; group width G = SYM_W*SYMS_PER_GRP (default one byte). Must be ≥ 2.
- CNT_W, $clog2(SYMS_PER_GRP), symbol index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- axiiv  in  1  input symbol valid; a deassertion ends the frame.
- axiid  in  SYM_W  input symbol.
- msb_first  in  1  1 = reverse symbol order within the group; 0 = pass through in order. Sampled with the first symbol of each group.
- axiov  out  1  output symbol valid.
- axiod  out  SYM_W  output symbol.
- axiodrop  out  1  one-cycle pulse when a partial group is discarded.

Behaviour:
- Reset (rst_n low, asynchronous) clears immediately and holds while low:
  - axiov=0, axiod=0, axiodrop=0.
  - Both buffers empty, fill/drain counters 0, fill pointer to buffer 0.
- Fill side:
  - Each cycle with axiiv=1, axiid is written to the fill buffer at index wcnt, and wcnt increments.
  - At wcnt=SYMS_PER_GRP-1 with axiiv=1, the buffer is marked full and handed to the drain side. Its mode bit is the msb_first value captured at wcnt=0. The fill pointer toggles and wcnt wraps to 0.
- Drain side:
  - When a full buffer is handed over, draining starts the next cycle and emits one symbol per cycle for SYMS_PER_GRP cycles with axiov=1.
  - Order when the mode bit=1: index SYMS_PER_GRP-1 down to 0. Order when the mode bit=0: index 0 up to SYMS_PER_GRP-1.
  - Latency: the first output symbol of a group is valid in the cycle after its last input symbol, i.e. SYMS_PER_GRP cycles after its first input.
  - Drain then continues contiguously into the next buffer if that buffer became full on the final drain cycle. Otherwise axiov=0 and axiod=0.
  - Input rate ≤ 1 symbol/cycle and each drain takes exactly SYMS_PER_GRP cycles, so two buffers never overflow. No backpressure exists.
- Partial group:
  - axiiv=0 while 0<wcnt<SYMS_PER_GRP marks the end of the frame.
  - The fill buffer contents are discarded, wcnt returns to 0 and the fill pointer is unchanged.
  - axiodrop=1 for exactly one cycle, the cycle after axiiv falls.
  - Any group already draining completes unaffected.
- Idle gaps at group boundaries (wcnt=0) are legal: no drop, no output.
- Simultaneous events:
  - A handover on the same cycle as the final drain symbol of the previous group gives seamless output.
  - A partial-group drop on a cycle with active drain gives axiodrop and axiov both high.
- Reset mid-operation: all in-flight data is lost and no further axiov occurs until a new full group arrives.
- msb_first changing mid-group has no effect until the next group starts.

Decomposition:
- Package bitorder_pkg holds:
  - enum of the drain state (IDLE, DRAIN);
  - localparam defaults RMII_SYM_W=2 and MII_SYM_W=4;
  - a function computing the drain index from count and mode.
- One sub-module, grp_buf: a single SYMS_PER_GRP×SYM_W register buffer with a write port, a read-index port, and full/mode flags. It is instantiated twice for the ping-pong.

Test Plan:
- Defaults, msb_first=1, single group:
  - Stimulus: axiid 01,01,01,11 on cycles 0–3, then axiiv=0.
  - Required: axiov=1 with axiod 11,01,01,01 on cycles 4–7; axiov=0 on cycle 8; axiodrop never asserted.
- Three back-to-back groups:
  - Stimulus: 01,01,01,11 | 00,01,10,10 | 11,00,11,01.
  - Required: contiguous axiov on cycles 4–15 with axiod 11,01,01,01,10,10,01,00,01,11,00,11; no bubble at group boundaries.
- Partial group:
  - Stimulus: 01,01,01,11,00,01, then axiiv=0 at cycle 6.
  - Required: output 11,01,01,01 on cycles 4–7; axiodrop=1 on cycle 7 only; no further axiov.
- Mode and parameter sweep:
  - Defaults with msb_first=0: input 01,10,11,00 gives output 01,10,11,00.
  - SYM_W=4, SYMS_PER_GRP=2 with msb_first=1: input A,5 gives output 5,A one cycle after the last nibble.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 asynchronously (between edges) during the second output symbol.
  - Required: axiov=0 and axiod=0 immediately. After release, a new group produces correct output with latency SYMS_PER_GRP.
- Idle gap at group boundary:
  - Stimulus: one full group, 3 idle cycles, another full group.
  - Required: two correct output bursts and no axiodrop.
